// File: rtl/lsu_mmio_v3_if.sv
// Request/response handshake bundle between the MEM stage (master) and the LSU (slave).
// Signal suffixes are named from the LSU's point of view.
interface lsu_mmio_v3_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/lsu_mmio_v3.sv
// Load/store unit with banked sync-read DMEM, board I/O buffers and access-fault detection.
// Optional LSU_BTN_DEBOUNCE_EN adds per-button debounce counters after the synchronisers.
module lsu_mmio_v3 #(
  parameter int DMEM_DEPTH_WORDS    = 16384,
  parameter int NUM_HEX             = 6,
  parameter int BTN_WIDTH           = 4,
  parameter int BTN_DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  lsu_mmio_v3_if.slave           bus,
  input  logic [31:0]            io_sw_i,
  input  logic [BTN_WIDTH-1:0]   io_btn_i,
  output logic [31:0]            io_ledr_o,
  output logic [7*NUM_HEX-1:0]   io_hex_o,
  output logic [31:0]            io_lcd_o
);
  localparam int AW = $clog2(DMEM_DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] REG_DMEM = 2'b01;
  localparam logic [1:0] REG_OBUF = 2'b10;
  localparam logic [1:0] REG_IBUF = 2'b11;

  function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                        input logic [17:0] a);
    logic f;
    f = (a[17:16] == 2'b00);
    if (we) f = f || !(f3 inside {3'b000, 3'b001, 3'b010}) || (a[17:16] == REG_IBUF);
    else    f = f || (f3 inside {3'b011, 3'b110, 3'b111});
    if (f3[1:0] == 2'b01 && a[0])          f = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) f = 1'b1;
    return f;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, fault, commit, dmem_we, obuf_we;
  logic [3:0]  be;
  logic [31:0] wlane, dmem_rd, ld_word;
  logic [7:0]  obuf_q [32];
  logic [31:0] sw_s1_q, sw_s2_q;
  logic [BTN_WIDTH-1:0] btn_s1_q, btn_s2_q, btn_val;
  logic [7:0]  btn8;
  logic        unused_bits;

  assign accept  = bus.req_valid_i && bus.req_ready_o;
  assign fault   = access_fault(we_q, f3_q, addr_q);
  assign commit  = (state_q == BUSY) && we_q && !fault;
  assign dmem_we = commit && (addr_q[17:16] == REG_DMEM);
  assign obuf_we = commit && (addr_q[17:16] == REG_OBUF);
  assign be      = byte_en(f3_q[1:0], addr_q[1:0]);
  assign wlane   = store_lanes(f3_q[1:0], wdata_q);

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

  assign unused_bits = ^{addr_q, bus.req_addr_i[31:18]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == BUSY) begin
        err_q   <= fault;
        rdata_q <= (fault || we_q) ? 32'h0 : load_extend(f3_q, addr_q[1:0], ld_word);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= bus.req_we_i;
      f3_q    <= bus.req_funct3_i;
      addr_q  <= bus.req_addr_i[17:0];
      wdata_q <= bus.req_wdata_i;
    end
  end

  // DMEM read is launched on the accept edge so data is ready during BUSY
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] mem [DMEM_DEPTH_WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge clk_i) begin
      if (dmem_we && be[b]) mem[addr_q[AW+1:2]] <= wlane[8*b +: 8];
      if (accept)           rd_q <= mem[bus.req_addr_i[AW+1:2]];
    end
    assign dmem_rd[8*b +: 8] = rd_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obuf_q <= '{default: 8'h00};
    end else if (obuf_we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) obuf_q[{addr_q[4:2], 2'(b)}] <= wlane[8*b +: 8];
    end
  end

  assign io_ledr_o = {obuf_q[3], obuf_q[2], obuf_q[1], obuf_q[0]};
  assign io_lcd_o  = {obuf_q[19], obuf_q[18], obuf_q[17], obuf_q[16]};
  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    assign io_hex_o[7*i +: 7] = obuf_q[4+i][6:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= io_sw_i;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= io_btn_i;
      btn_s2_q <= btn_s1_q;
    end
  end

`ifdef LSU_BTN_DEBOUNCE_EN
  localparam int CW = $clog2(BTN_DEBOUNCE_CYCLES + 1);
  logic [CW-1:0]        cnt_q [BTN_WIDTH];
  logic [BTN_WIDTH-1:0] deb_q;

  // A button flips only after disagreeing with its debounced value for the full window
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q <= '0;
      for (int i = 0; i < BTN_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_WIDTH; i++) begin
        if (btn_s2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CW'(BTN_DEBOUNCE_CYCLES - 1)) begin
            deb_q[i] <= btn_s2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end
  assign btn_val = deb_q;
`else
  assign btn_val = btn_s2_q;
`endif

  always_comb begin
    btn8 = '0;
    btn8[BTN_WIDTH-1:0] = btn_val;
  end

  always_comb begin
    ld_word = '0;
    case (addr_q[17:16])
      REG_DMEM: ld_word = dmem_rd;
      REG_OBUF: ld_word = {obuf_q[{addr_q[4:2], 2'd3}], obuf_q[{addr_q[4:2], 2'd2}],
                           obuf_q[{addr_q[4:2], 2'd1}], obuf_q[{addr_q[4:2], 2'd0}]};
      REG_IBUF: ld_word = addr_q[2] ? {24'b0, btn8} : sw_s2_q;
      default:  ld_word = '0;
    endcase
  end
endmodule

// File: tb/tb_lsu_mmio_v3.sv
// Randomised self-checking bench for lsu_mmio_v3 with a byte-level reference model.
// Works with or without LSU_BTN_DEBOUNCE_EN defined.
module tb_lsu_mmio_v3;
  localparam int DEPTH   = 1024;
  localparam int NHEX    = 6;
  localparam int BW      = 4;
  localparam int DEB     = 8;
  localparam int SETTLE  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] io_sw;
  logic [BW-1:0] io_btn;
  logic [31:0] ledr, lcd;
  logic [7*NHEX-1:0] hex;

  int checks = 0;
  int errors = 0;

  lsu_mmio_v3_if bus();

  lsu_mmio_v3 #(
    .DMEM_DEPTH_WORDS(DEPTH), .NUM_HEX(NHEX), .BTN_WIDTH(BW), .BTN_DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .io_sw_i(io_sw), .io_btn_i(io_btn),
    .io_ledr_o(ledr), .io_hex_o(hex), .io_lcd_o(lcd)
  );

  always #5 clk = ~clk;

  // Reference state: DMEM bytes keyed by word_index*4+lane, output buffer bytes, input values
  logic [7:0]  m_dmem [int];
  logic [7:0]  m_obuf [32];
  logic [31:0] m_sw;
  logic [7:0]  m_btn;

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int sz, rg;
    logic [31:0] v;
    rg = int'(a[17:16]);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    er = 1'b0;
    rd = 32'h0;
    if (rg == 0) er = 1'b1;
    if (we && (f3 > 3'd2 || rg == 3)) er = 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) er = 1'b1;
    if ((a % sz) != 0) er = 1'b1;
    if (er) return;
    v = 32'h0;
    for (int j = 0; j < sz; j++) begin
      int key;
      logic [7:0] by;
      by = 8'h00;
      if (rg == 1) begin
        key = int'(a[11:2]) * 4 + int'(a[1:0]) + j;
        if (we) m_dmem[key] = 8'((wd >> (8 * j)) & 32'hFF);
        else if (m_dmem.exists(key)) by = m_dmem[key];
      end else if (rg == 2) begin
        key = int'(a[4:0]) + j;
        if (we) m_obuf[key] = 8'((wd >> (8 * j)) & 32'hFF);
        else by = m_obuf[key];
      end else begin
        key = int'(a[2:0]) + j;
        if (key < 4) by = 8'((m_sw >> (8 * key)) & 32'hFF);
        else if (key == 4) by = m_btn;
      end
      v = v | (32'(by) << (8 * j));
    end
    if (!we) begin
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  function automatic logic [31:0] exp_ledr();
    return {m_obuf[3], m_obuf[2], m_obuf[1], m_obuf[0]};
  endfunction
  function automatic logic [31:0] exp_lcd();
    return {m_obuf[19], m_obuf[18], m_obuf[17], m_obuf[16]};
  endfunction
  function automatic logic [7*NHEX-1:0] exp_hex();
    logic [7*NHEX-1:0] h;
    for (int i = 0; i < NHEX; i++) h[7*i +: 7] = m_obuf[4+i][6:0];
    return h;
  endfunction

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_funct3_i = f3;
    bus.req_addr_i = a; bus.req_wdata_i = wd; bus.rsp_ready_i = 1'b0;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 0;
    @(negedge clk);
    while (bus.rsp_valid_o !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    rd = bus.rsp_rdata_o;
    er = bus.rsp_err_o;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    if (lat >= 20 || n >= 20) lat = -1;
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output logic [31:0] erd, output logic eer, output int lat);
    model(we, f3, a, wd, erd, eer);
    access(we, f3, a, wd, rd, er, lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata_o); end
    checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.rsp_err_o); end
    checks++; if (ledr !== 32'h0) begin errors++; $display("FAIL reset_ledr got %h want 0", ledr); end
    checks++; if (hex !== '0) begin errors++; $display("FAIL reset_hex got %h want 0", hex); end
    checks++; if (lcd !== 32'h0) begin errors++; $display("FAIL reset_lcd got %h want 0", lcd); end
  endtask

  task automatic test_extend();
    logic [31:0] rd, erd; logic er, eer; int lat;
    logic [31:0] exp_v [4];
    logic [2:0]  f3s [4];
    logic [31:0] ads [4];
    exp_v = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8000, 32'h0000_8000};
    f3s   = '{3'b000, 3'b100, 3'b001, 3'b101};
    ads   = '{32'h0001_0004, 32'h0001_0004, 32'h0001_0006, 32'h0001_0006};
    xact(1'b1, 3'b010, 32'h0001_0004, 32'h8000_00F1, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL ext_sw_err got %b want 0", er); end
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, f3s[i], ads[i], 32'h0, rd, er, erd, eer, lat);
      checks++;
      if (rd !== exp_v[i] || er !== 1'b0) begin
        errors++; $display("FAIL ext_load%0d got %h/%b want %h/0", i, rd, er, exp_v[i]);
      end
    end
  endtask

  task automatic test_hex();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xact(1'b1, 3'b000, 32'h0002_0005, 32'h0000_00AB, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL hex_sb_err got %b want 0", er); end
    checks++; if (hex[13:7] !== 7'h2B) begin errors++; $display("FAIL hex1 got %h want 2b", hex[13:7]); end
    xact(1'b0, 3'b010, 32'h0002_0004, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h0000_AB00 || er !== 1'b0) begin
      errors++; $display("FAIL hex_readback got %h/%b want 0000ab00/0", rd, er); end
  endtask

  task automatic test_faults();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xact(1'b0, 3'b010, 32'h0001_0002, 32'h0, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL flt_lw_mis got %h/%b want 0/1", rd, er); end
    xact(1'b1, 3'b010, 32'h0001_0000, 32'h1122_3344, rd, er, erd, eer, lat);
    xact(1'b1, 3'b001, 32'h0001_0001, 32'hAAAA_BBBB, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL flt_sh_mis got %b want 1", er); end
    xact(1'b0, 3'b010, 32'h0001_0000, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin errors++; $display("FAIL flt_old_value got %h want 11223344", rd); end
    xact(1'b0, 3'b010, 32'h0000_0000, 32'h0, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL flt_unmapped got %h/%b want 0/1", rd, er); end
    xact(1'b1, 3'b010, 32'h0003_0000, 32'h5, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL flt_store_in got %b want 1", er); end
    xact(1'b0, 3'b011, 32'h0001_0000, 32'h0, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL flt_ld_f3 got %h/%b want 0/1", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held; int n;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b010;
    bus.req_addr_i = 32'h0001_0004; bus.req_wdata_i = 32'h0; bus.rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    held = bus.rsp_rdata_o;
    checks++; if (held !== 32'h8000_00F1) begin errors++; $display("FAIL bp_data got %h want 800000f1", held); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== held || bus.req_ready_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d valid=%b rdata=%h ready=%b want 1/%h/0", i,
                           bus.rsp_valid_o, bus.rsp_rdata_o, bus.req_ready_o, held);
      end
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b want 0/1", bus.rsp_valid_o, bus.req_ready_o); end
  endtask

  task automatic test_inputs();
    logic [31:0] rd, erd; logic er, eer; int lat;
    @(negedge clk);
    io_sw = 32'h1234_5678; io_btn = 4'b0101;
    m_sw = 32'h1234_5678; m_btn = 8'h05;
    repeat (3) @(negedge clk);
`ifdef LSU_BTN_DEBOUNCE_EN
    repeat (DEB + 4) @(negedge clk);
`endif
    xact(1'b0, 3'b010, 32'h0003_0000, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL in_sw got %h want 12345678", rd); end
    xact(1'b0, 3'b100, 32'h0003_0004, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h0000_0005 || er !== 1'b0) begin errors++; $display("FAIL in_btn got %h want 5", rd); end
    xact(1'b0, 3'b100, 32'h0003_0006, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL in_pad got %h want 0", rd); end
`ifdef LSU_BTN_DEBOUNCE_EN
    @(negedge clk);
    io_btn = 4'b1010;
    repeat (5) @(negedge clk);
    io_btn = 4'b0101;
    xact(1'b0, 3'b100, 32'h0003_0004, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL glitch_during got %h want 5", rd); end
    repeat (DEB + 4) @(negedge clk);
    xact(1'b0, 3'b100, 32'h0003_0004, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL glitch_after got %h want 5", rd); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic er, eer, we; int lat;
    logic [2:0] f3;
    logic [9:0] idx;
    @(negedge clk);
    io_sw = $urandom(); io_btn = BW'($urandom());
    m_sw = io_sw; m_btn = 8'(io_btn);
    repeat (SETTLE) @(negedge clk);
    for (int p = 0; p < 8; p++) begin
      idx = 10'(16 + p * 37);
      a = {14'h0, 2'b01, 4'($urandom()), idx, 2'b00};
      xact(1'b1, 3'b010, a, $urandom(), rd, er, erd, eer, lat);
    end
    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
      idx = 10'(16 + $urandom_range(0, 7) * 37);
      case ($urandom_range(0, 6))
        0:       a = {14'($urandom()), 2'b00, 16'($urandom())};
        1, 2:    a = {14'($urandom()), 2'b10, 11'($urandom()), 5'($urandom())};
        3:       a = {14'($urandom()), 2'b11, 16'($urandom())};
        default: a = {14'($urandom()), 2'b01, 4'($urandom()), idx, 2'($urandom())};
      endcase
      wd = $urandom();
      xact(we, f3, a, wd, rd, er, erd, eer, lat);
      checks++;
      if (rd !== erd || er !== eer) begin
        errors++; $display("FAIL rand%0d we=%b f3=%0d a=%h got %h/%b want %h/%b", t, we, f3, a, rd, er, erd, eer);
      end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL rand_lat%0d got %0d want 1", t, lat); end
      if (we && a[17:16] == 2'b10) begin
        checks++;
        if (ledr !== exp_ledr() || hex !== exp_hex() || lcd !== exp_lcd()) begin
          errors++; $display("FAIL rand_io%0d ledr=%h hex=%h lcd=%h want %h %h %h", t,
                             ledr, hex, lcd, exp_ledr(), exp_hex(), exp_lcd());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = 3'b010;
    bus.req_addr_i = 32'h0002_0000; bus.req_wdata_i = 32'hFFFF_FFFF; bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_busy ready got %b want 0", bus.req_ready_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL rmid_async valid=%b ready=%b want 0/1", bus.rsp_valid_o, bus.req_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ledr !== 32'h0 || bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL rmid_after ledr=%h valid=%b ready=%b want 0/0/1", ledr, bus.rsp_valid_o, bus.req_ready_o); end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b0;
    bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0; bus.rsp_ready_i = 1'b0;
    io_sw = 32'h0; io_btn = '0;
    m_sw = 32'h0; m_btn = 8'h0;
    for (int i = 0; i < 32; i++) m_obuf[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_extend();
    test_hex();
    test_faults();
    test_backpressure();
    test_inputs();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
